// File: rtl/spi_pkg.sv
// Shared definitions for the SPI burst master: FSM state encoding, default
// word geometry and the half-period counter width helper.
package spi_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int N_WORDS_DEF = 6;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP,
        DONE
    } spi_state_t;

    // Bits needed to count 0..clk_div-1 system clocks inside one SCLK half-period
    function automatic int hp_cnt_w(input int clk_div);
        return (clk_div <= 2) ? 1 : $clog2(clk_div);
    endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// One-word SPI mode-0 bit engine: half-period tick generator plus the shared
// TX/RX shift register. The burst FSM in the top decides which phase is
// active; this block only produces SCLK edges and moves bits.
module spi_bit_engine
    import spi_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CLK_DIV = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_shift,
    input  logic              i_go,
    input  logic [DATA_W-1:0] i_tx_word,
    input  logic              i_miso,
    output logic              o_tick,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rx_word,
    output logic              o_sclk,
    output logic              o_mosi
);

    localparam int CNT_W = hp_cnt_w(CLK_DIV);
    localparam int HP_W  = $clog2(2 * DATA_W + 1);

    logic [CNT_W-1:0]  r_cnt;
    logic [HP_W-1:0]   r_hp;
    logic [DATA_W-1:0] r_sreg;
    logic              r_sclk;
    logic              r_mosi;
    logic              w_last;
    logic              w_edge;

    // r_hp counts SCLK edges already produced in this word; edge 2*DATA_W is the last fall
    assign o_tick    = i_en && (r_cnt == CNT_W'(CLK_DIV - 1));
    assign w_last    = (r_hp == HP_W'(2 * DATA_W));
    assign w_edge    = o_tick && i_shift && !w_last;
    assign o_done    = o_tick && i_shift && w_last;
    assign o_rx_word = r_sreg;
    assign o_sclk    = r_sclk;
    assign o_mosi    = r_mosi;

    // Half-period divider: free-runs while the burst is active, parks at zero otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_en || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // SCLK/MOSI pins: odd edges raise SCLK, even edges lower it and present the next bit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk <= 1'b0;
            r_mosi <= 1'b0;
            r_hp   <= '0;
        end else if (i_go) begin
            r_sclk <= 1'b0;
            r_mosi <= i_tx_word[DATA_W-1];
            r_hp   <= '0;
        end else if (w_edge) begin
            r_hp <= r_hp + HP_W'(1);
            if (!r_hp[0]) begin
                r_sclk <= 1'b1;
            end else begin
                r_sclk <= 1'b0;
                r_mosi <= (r_hp == HP_W'(2 * DATA_W - 1)) ? 1'b0 : r_sreg[DATA_W-1];
            end
        end
    end

    // Shift register: MSB already copied to MOSI at load, so each rise shifts MISO in at the LSB
    always_ff @(posedge i_clk) begin
        if (i_go) begin
            r_sreg <= i_tx_word;
        end else if (w_edge && !r_hp[0]) begin
            r_sreg <= {r_sreg[DATA_W-2:0], i_miso};
        end
    end

endmodule

// File: rtl/spi_master_burst.sv
// SPI burst master between the Nios PIO exports and the DSP SPI pins.
// A 0->nonzero edge on start_spi in IDLE snapshots the mask and all TX words,
// then each selected word is sent in ascending index order with an inter-word
// gap of max(delay_spi,1) SCLK half-periods; end_spi flags burst completion.
// Build option SPI_LOOPBACK_EN: sample the internal MOSI register instead of
// spi_miso (board self-test); pins and timing are unchanged.
module spi_master_burst
    import spi_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int N_WORDS = N_WORDS_DEF,
    parameter int CLK_DIV = 4
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    input  logic [N_WORDS-1:0]        start_spi,
    input  logic [7:0]                delay_spi,
    input  logic [N_WORDS*DATA_W-1:0] tx_data,
    output logic [N_WORDS*DATA_W-1:0] rx_data,
    output logic                      end_spi,
    output logic                      spi_sclk,
    output logic                      spi_mosi,
    input  logic                      spi_miso,
    output logic                      spi_cs_n
);

    localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    spi_state_t                r_state;
    spi_state_t                w_state_nxt;
    logic [N_WORDS-1:0]        r_start_q;
    logic [N_WORDS-1:0]        r_pend;
    logic [IDX_W-1:0]          r_idx;
    logic [7:0]                r_gap;
    logic                      r_cs_n;
    logic                      r_end;
    logic [N_WORDS*DATA_W-1:0] r_tx;
    logic [N_WORDS*DATA_W-1:0] r_rx;

    logic                      w_accept;
    logic                      w_go;
    logic                      w_wb;
    logic                      w_tick;
    logic                      w_done;
    logic                      w_run;
    logic                      w_shift;
    logic                      w_miso;
    logic                      w_mosi;
    logic [N_WORDS-1:0]        w_go_mask;
    logic [IDX_W-1:0]          w_go_idx;
    logic [DATA_W-1:0]         w_go_word;
    logic [DATA_W-1:0]         w_rx_word;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_WORDS-1:0] m);
        lowest_idx = '0;
        for (int i = N_WORDS - 1; i >= 0; i--) begin
            if (m[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

    function automatic logic [DATA_W-1:0] pick_word(input logic [N_WORDS*DATA_W-1:0] bus,
                                                    input logic [IDX_W-1:0] idx);
        pick_word = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            if (idx == IDX_W'(i)) pick_word = bus[i*DATA_W +: DATA_W];
        end
    endfunction

    // Only a fresh rising request in IDLE starts a burst; a held or mid-burst mask is ignored
    assign w_accept  = (r_state == IDLE) && (r_start_q == '0) && (start_spi != '0);
    assign w_run     = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD) || (r_state == GAP);
    assign w_shift   = (r_state == SETUP) || (r_state == SHIFT);
    // The first word comes straight off the pins because the snapshot lands on the same edge
    assign w_go_mask = (r_state == IDLE) ? start_spi : r_pend;
    assign w_go_idx  = lowest_idx(w_go_mask);
    assign w_go_word = (r_state == IDLE) ? pick_word(tx_data, w_go_idx) : pick_word(r_tx, w_go_idx);

`ifdef SPI_LOOPBACK_EN
    assign w_miso = w_mosi;
`else
    assign w_miso = spi_miso;
`endif

    spi_bit_engine #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_bit_engine (
        .i_clk     (clk_clk),
        .i_rst_n   (reset_reset_n),
        .i_en      (w_run),
        .i_shift   (w_shift),
        .i_go      (w_go),
        .i_tx_word (w_go_word),
        .i_miso    (w_miso),
        .o_tick    (w_tick),
        .o_done    (w_done),
        .o_rx_word (w_rx_word),
        .o_sclk    (spi_sclk),
        .o_mosi    (w_mosi)
    );

    assign spi_mosi = w_mosi;
    assign spi_cs_n = r_cs_n;
    assign end_spi  = r_end;
    assign rx_data  = r_rx;

    // Burst sequencing: next state plus word-load and RX write-back strobes
    always_comb begin
        w_state_nxt = r_state;
        w_go        = 1'b0;
        w_wb        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SETUP;
                    w_go        = 1'b1;
                end
            end
            SETUP: if (w_tick) w_state_nxt = SHIFT;
            SHIFT: if (w_done) w_state_nxt = HOLD;
            HOLD: begin
                if (w_tick) begin
                    w_wb        = 1'b1;
                    w_state_nxt = (r_pend != '0) ? GAP : DONE;
                end
            end
            GAP: begin
                if (w_tick && (r_gap == 8'd1)) begin
                    w_state_nxt = SETUP;
                    w_go        = 1'b1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Control registers: state, request edge detect, pending mask, gap counter, CS and end flag
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state   <= IDLE;
            r_start_q <= '0;
            r_pend    <= '0;
            r_idx     <= '0;
            r_gap     <= 8'd0;
            r_cs_n    <= 1'b1;
            r_end     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_q <= start_spi;
            r_cs_n    <= !(w_state_nxt inside {SETUP, SHIFT, HOLD});
            if (w_go) begin
                r_idx  <= w_go_idx;
                r_pend <= w_go_mask & ~(N_WORDS'(1) << w_go_idx);
            end
            if (w_accept) begin
                r_end <= 1'b0;
            end else if (w_wb && (r_pend == '0)) begin
                r_end <= 1'b1;
            end
            if (w_wb) begin
                r_gap <= (delay_spi == 8'd0) ? 8'd1 : delay_spi;
            end else if ((r_state == GAP) && w_tick) begin
                r_gap <= r_gap - 8'd1;
            end
        end
    end

    // TX snapshot taken on the accepting edge; later pin changes do not affect the burst
    always_ff @(posedge clk_clk) begin
        if (w_accept) r_tx <= tx_data;
    end

    // RX write-back when CS rises; words not in the burst keep their old contents
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_rx <= '0;
        end else if (w_wb) begin
            for (int i = 0; i < N_WORDS; i++) begin
                if (r_idx == IDX_W'(i)) r_rx[i*DATA_W +: DATA_W] <= w_rx_word;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_burst.sv
// Self-checking bench for spi_master_burst: a mode-0 SPI slave model answers
// each CS window from a scoreboard of expected windows, checks MOSI content,
// window length, SCLK pulse count, inter-word gap and end_spi timing, and the
// burst driver checks rx_data against a reference image.
module tb_spi_master_burst;

    localparam int DW  = 16;
    localparam int NW  = 6;
    localparam int DIV = 4;

    typedef struct {
        logic [DW-1:0] mosi;
        logic [DW-1:0] resp;
        int            gap;
        bit            last;
    } win_t;

    logic             clk_clk;
    logic             reset_reset_n;
    logic [NW-1:0]    start_spi;
    logic [7:0]       delay_spi;
    logic [NW*DW-1:0] tx_data;
    logic [NW*DW-1:0] rx_data;
    logic             end_spi;
    logic             spi_sclk;
    logic             spi_mosi;
    logic             spi_miso;
    logic             spi_cs_n;

    int            n_vec;
    int            n_err;
    int            cyc;
    win_t          sb_q[$];
    win_t          cur;
    logic [DW-1:0] tx_w   [NW];
    logic [DW-1:0] resp_w [NW];
    logic [DW-1:0] exp_rx [NW];
    int            mon_rises;
    logic [DW-1:0] mosi_acc;
    int            open_cyc;
    int            close_cyc;
    int            end_rises;
    bit            abort_win;
    logic          cs_prev;
    logic          sclk_prev;
    logic          end_prev;

    spi_master_burst #(
        .DATA_W  (DW),
        .N_WORDS (NW),
        .CLK_DIV (DIV)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .start_spi     (start_spi),
        .delay_spi     (delay_spi),
        .tx_data       (tx_data),
        .rx_data       (rx_data),
        .end_spi       (end_spi),
        .spi_sclk      (spi_sclk),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .spi_cs_n      (spi_cs_n)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    always @(posedge clk_clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave model and window monitor, sampled on the falling system clock edge
    initial begin
        cs_prev   = 1'b1;
        sclk_prev = 1'b0;
        end_prev  = 1'b0;
        mon_rises = 0;
        end_rises = 0;
        spi_miso  = 1'b0;
    end

    always @(negedge clk_clk) begin
        if (cs_prev === 1'b1 && spi_cs_n === 1'b0) begin
            mon_rises = 0;
            mosi_acc  = '0;
            open_cyc  = cyc;
            chk("win_expected", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                cur = sb_q[0];
                if (cur.gap >= 0) chk("gap_cycles", cyc - close_cyc, cur.gap * DIV);
            end else begin
                cur.mosi = '0;
                cur.resp = '0;
                cur.gap  = -1;
                cur.last = 1'b0;
            end
        end else if (cs_prev === 1'b0 && spi_cs_n === 1'b1) begin
            close_cyc = cyc;
            if (!abort_win && sb_q.size() != 0) begin
                chk("win_len", cyc - open_cyc, (2 * DW + 2) * DIV);
                chk("sclk_pulses", mon_rises, DW);
                chk("mosi_word", mosi_acc, cur.mosi);
                chk("end_at_cs", end_spi, cur.last);
                void'(sb_q.pop_front());
            end
        end else if (spi_cs_n === 1'b0 && spi_sclk === 1'b1 && sclk_prev === 1'b0) begin
            mon_rises = mon_rises + 1;
            mosi_acc  = {mosi_acc[DW-2:0], spi_mosi};
        end
        if (end_spi === 1'b1 && end_prev === 1'b0) end_rises = end_rises + 1;
        spi_miso  = (spi_cs_n === 1'b0 && mon_rises < DW) ? cur.resp[DW-1-mon_rises] : 1'b0;
        cs_prev   = spi_cs_n;
        sclk_prev = spi_sclk;
        end_prev  = end_spi;
    end

    task automatic drive_tx();
        for (int i = 0; i < NW; i++) tx_data[i*DW +: DW] = tx_w[i];
    endtask

    task automatic check_rx();
        for (int i = 0; i < NW; i++) chk($sformatf("rx%0d", i), rx_data[i*DW +: DW], exp_rx[i]);
    endtask

    // Queue the expected windows, launch the burst, wait for end_spi, then check RX image
    task automatic run_burst(input logic [NW-1:0] mask, input logic [7:0] dly, input bit poke);
        win_t e;
        bit   first;
        int   n;
        first = 1'b1;
        for (int i = 0; i < NW; i++) begin
            if (mask[i]) begin
                e.mosi = tx_w[i];
                e.resp = resp_w[i];
                e.gap  = first ? -1 : ((dly == 8'd0) ? 1 : int'(dly));
                e.last = ((mask >> (i + 1)) == '0);
                sb_q.push_back(e);
                exp_rx[i] = resp_w[i];
                first = 1'b0;
            end
        end
        @(negedge clk_clk);
        drive_tx();
        delay_spi = dly;
        start_spi = mask;
        @(negedge clk_clk);
        chk("end_clr", end_spi, 1'b0);
        n = 0;
        while (end_spi !== 1'b1 && n < 20000) begin
            @(negedge clk_clk);
            n++;
            if (poke && n == 40) start_spi = '0;
            if (poke && n == 41) begin
                start_spi = 6'b000010;
                tx_data   = ~tx_data;
            end
        end
        chk("end_set", end_spi, 1'b1);
        @(negedge clk_clk);
        chk("sb_empty", sb_q.size(), 0);
        check_rx();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    initial begin
        int er0;
        int n;
        n_vec         = 0;
        n_err         = 0;
        abort_win     = 1'b0;
        reset_reset_n = 1'b0;
        start_spi     = '0;
        delay_spi     = 8'd0;
        tx_data       = '0;
        for (int i = 0; i < NW; i++) begin
            tx_w[i]   = '0;
            resp_w[i] = '0;
            exp_rx[i] = '0;
        end
        idle(3);
        chk("rst_cs_n", spi_cs_n, 1'b1);
        chk("rst_sclk", spi_sclk, 1'b0);
        chk("rst_mosi", spi_mosi, 1'b0);
        chk("rst_end", end_spi, 1'b0);
        chk("rst_rx", (rx_data != '0), 1'b0);
        reset_reset_n = 1'b1;
        idle(2);

        // single word, slave echoes the pattern
        tx_w[0] = 16'hA5C3; resp_w[0] = 16'hA5C3;
        run_burst(6'b000001, 8'd0, 1'b0);
        start_spi = '0; idle(2);

        // slave answers a different word than the one sent
        tx_w[1] = 16'hFFFF; resp_w[1] = 16'h1234;
        run_burst(6'b000010, 8'd0, 1'b0);
        start_spi = '0; idle(2);

        // sparse mask with a 3 half-period gap; rx1/3/4 must survive
        tx_w[0] = 16'h1111; resp_w[0] = 16'h1111;
        tx_w[2] = 16'h2222; resp_w[2] = 16'h2222;
        tx_w[5] = 16'h5555; resp_w[5] = 16'h5555;
        run_burst(6'b100101, 8'd3, 1'b0);
        start_spi = '0; idle(2);

        // zero delay still gives one half-period gap; top two slots
        tx_w[4] = 16'h8001; resp_w[4] = 16'hC0DE;
        tx_w[5] = 16'h7FFE; resp_w[5] = 16'h0001;
        run_burst(6'b110000, 8'd0, 1'b0);
        start_spi = '0; idle(2);

        // mid-burst request and TX change are ignored
        er0 = end_rises;
        tx_w[0] = 16'hBEEF; resp_w[0] = 16'h5A5A;
        run_burst(6'b000001, 8'd0, 1'b1);
        idle(300);
        chk("end_once", end_rises - er0, 1);
        start_spi = '0; idle(2);

        // asynchronous reset partway through word 0
        tx_w[0] = 16'h0F0F; resp_w[0] = 16'h7777;
        tx_w[1] = 16'h3C3C; resp_w[1] = 16'h8888;
        abort_win = 1'b1;
        cur.mosi = tx_w[0]; cur.resp = resp_w[0]; cur.gap = -1; cur.last = 1'b0;
        sb_q.push_back(cur);
        @(negedge clk_clk);
        drive_tx();
        start_spi = 6'b000011;
        n = 0;
        while (mon_rises < 7 && n < 2000) begin
            @(negedge clk_clk);
            n++;
        end
        chk("rst_reach_bit7", (n < 2000), 1'b1);
        @(posedge clk_clk);
        #2;
        reset_reset_n = 1'b0;
        start_spi     = '0;
        #1;
        chk("mid_rst_cs_n", spi_cs_n, 1'b1);
        chk("mid_rst_sclk", spi_sclk, 1'b0);
        chk("mid_rst_mosi", spi_mosi, 1'b0);
        chk("mid_rst_end", end_spi, 1'b0);
        chk("mid_rst_rx", (rx_data != '0), 1'b0);
        sb_q.delete();
        for (int i = 0; i < NW; i++) exp_rx[i] = '0;
        idle(3);
        reset_reset_n = 1'b1;
        abort_win     = 1'b0;
        idle(2);
        tx_w[2] = 16'h6C6C; resp_w[2] = 16'h9393;
        run_burst(6'b000100, 8'd2, 1'b0);
        start_spi = '0; idle(2);

        // held mask does not restart; release and re-assert does
        er0 = end_rises;
        tx_w[0] = 16'hCAFE; resp_w[0] = 16'h0FF0;
        run_burst(6'b000001, 8'd0, 1'b0);
        idle(300);
        chk("end_hold", end_spi, 1'b1);
        chk("held_no_restart", end_rises - er0, 1);
        start_spi = '0; idle(2);
        tx_w[0] = 16'h1357; resp_w[0] = 16'h2468;
        run_burst(6'b000001, 8'd0, 1'b0);
        chk("rearm_end_rises", end_rises - er0, 2);
        start_spi = '0; idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "watchdog");
    end

endmodule
